rtc_bus_scheduler: RTL
======================

Name: rtc_bus_scheduler

Overview:
- Sequences all accesses to the shared multiplexed RTC bus.
- Arbitrates between three requesters: user write (clock/timer/date set), user read, and an internal periodic refresh read.
- Drives the write-machine start (escribe) and read-machine start (lee), and waits for each machine's completion strobe (t_esc / t_lect).
- Enforces an inter-transaction guard gap and bounds refresh starvation. Sits between the main control FSM and the write/read machines.

Parameters:
- REFRESH_CYCLES, 1000000, clk cycles between periodic refresh requests (>=2)
- GAP_CYCLES, 4, idle guard cycles after each transaction (0 allowed)
- TIMEOUT_CYCLES, 4096, watchdog limit per transaction (used only with SCHED_TIMEOUT_EN)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- wr_req  in  1  user write request; level, held until wr_ack
- rd_req  in  1  user read request; level, held until rd_ack
- t_esc  in  1  write-machine completion pulse
- t_lect  in  1  read-machine completion pulse
- escribe  out  1  write transaction active (level)
- lee  out  1  read transaction active (level)
- wr_ack  out  1  one-cycle pulse: user write finished
- rd_ack  out  1  one-cycle pulse: user read finished
- refresh_done  out  1  one-cycle pulse: refresh read finished
- busy  out  1  high in any state other than IDLE
- src  out  2  owner of current/last transaction: 00 none, 01 write, 10 user read, 11 refresh
- timeout_err  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset:
  - state=IDLE; all outputs 0; src=00.
  - Refresh counter=0; refresh_pend=0; last_user=0.
  - Reset mid-transaction aborts immediately. escribe/lee drop on the next edge and no ack is issued.
- Refresh counter:
  - Free-runs 0..REFRESH_CYCLES-1 and wraps.
  - At terminal count sets refresh_pend.
  - refresh_pend clears when a refresh is granted. It never accumulates: a second tick while pending is lost.
- States: IDLE, WRITE, READ, GAP.
- IDLE arbitration (evaluated each edge):
  - If refresh_pend and last_user=1, refresh wins.
  - Otherwise priority is wr_req > rd_req > refresh_pend.
- Grant latency:
  - A request sampled at edge k enters WRITE/READ at k+1.
  - escribe/lee are high from k+1. src updates at k+1.
  - last_user is set on a user grant and cleared on a refresh grant.
- WRITE:
  - escribe=1 until t_esc is sampled high.
  - On that edge: go to GAP, escribe=0, wr_ack=1 for exactly one cycle.
- READ:
  - lee=1 until t_lect is sampled high.
  - On that edge: go to GAP, lee=0.
  - Pulse rd_ack if src=10, or refresh_done if src=11.
- Strobe filtering:
  - t_esc is ignored outside WRITE; t_lect is ignored outside READ.
  - Simultaneous t_esc and t_lect: only the strobe matching the state counts.
- GAP:
  - Stays exactly GAP_CYCLES cycles, then IDLE. No grant is possible during GAP.
  - GAP_CYCLES=0: go straight to IDLE; a new grant can occur on the edge after the ack.
- Requester rules:
  - Dropping wr_req/rd_req mid-transaction does not abort; the ack still pulses.
  - A requester must deassert on the ack cycle. A request still high in IDLE is treated as new.
- escribe and lee are never high together. busy=0 only in IDLE.
- src holds its value through GAP and IDLE until the next grant.

Optional Feature:
- SCHED_TIMEOUT_EN defined:
  - A watchdog counts cycles in WRITE/READ and resets on each grant.
  - When TIMEOUT_CYCLES elapse with no completion strobe, the transaction aborts: escribe/lee drop and the state goes to GAP.
  - timeout_err and the normal ack for the src pulse together for one cycle, so the requester never hangs.
  - For a refresh abort, refresh_pend is not re-armed.
- SCHED_TIMEOUT_EN undefined:
  - The block waits indefinitely for the completion strobe.
  - timeout_err is tied to 0 and there is no watchdog logic.

Test Plan:
All scenarios use REFRESH_CYCLES=20, GAP_CYCLES=2, TIMEOUT_CYCLES=8.
- Reset, then idle 19 cycles → refresh_pend set at cycle 19; lee high at cycle 21, src=11. t_lect 3 cycles later → refresh_done pulse, busy low 2 cycles after it.
- wr_req and rd_req raised on the same edge → escribe next cycle, src=01. After t_esc: wr_ack, then 2 GAP cycles, then lee with src=10.
- wr_req held continuously while a refresh is pending after a user write → refresh granted before the next write (last_user rule). The next write follows the refresh gap.
- t_lect pulsed while in WRITE → ignored, escribe stays 1. t_esc then completes normally; no rd_ack.
- Reset asserted 2 cycles into WRITE → escribe=0 next cycle, no wr_ack, state IDLE, counter restarts at 0.
- With SCHED_TIMEOUT_EN, rd_req with no t_lect → lee drops after 8 cycles; timeout_err and rd_ack pulse together. Without the macro, lee stays high for 100+ cycles.

Source files
------------

// File: rtl/rtc_bus_scheduler_if.sv
// -----------------------------------------------------------------------------
// rtc_bus_scheduler_if
// Handshake bundle between the RTC bus scheduler, the main control FSM
// (wr_req / rd_req and their acks) and the write/read machines
// (escribe / lee starts and their t_esc / t_lect completion strobes).
//
// Signals:
//   wr_req, rd_req      user requests (level, held until the matching ack)
//   t_esc, t_lect       write / read machine completion pulses
//   escribe, lee        write / read transaction active (level)
//   wr_ack, rd_ack      one-cycle user completion pulses
//   refresh_done        one-cycle pulse when a periodic refresh read finishes
//   busy                scheduler is not idle
//   src[1:0]            owner of current/last transaction (00/01/10/11)
//   timeout_err         one-cycle pulse on watchdog abort
//
// Modports:
//   master  - the scheduler itself (drives starts, acks and status)
//   slave   - the surrounding logic (drives requests and strobes)
// -----------------------------------------------------------------------------
interface rtc_bus_scheduler_if;
    logic       wr_req;
    logic       rd_req;
    logic       t_esc;
    logic       t_lect;
    logic       escribe;
    logic       lee;
    logic       wr_ack;
    logic       rd_ack;
    logic       refresh_done;
    logic       busy;
    logic [1:0] src;
    logic       timeout_err;

    modport master (
        input  wr_req, rd_req, t_esc, t_lect,
        output escribe, lee, wr_ack, rd_ack, refresh_done, busy, src, timeout_err
    );

    modport slave (
        output wr_req, rd_req, t_esc, t_lect,
        input  escribe, lee, wr_ack, rd_ack, refresh_done, busy, src, timeout_err
    );
endinterface

// File: rtl/rtc_bus_scheduler.sv
// -----------------------------------------------------------------------------
// rtc_bus_scheduler
// Sequences every access to the shared multiplexed RTC bus. Arbitrates between
// a user write, a user read and an internal periodic refresh read, starts the
// write machine (escribe) or read machine (lee), waits for its completion
// strobe, then holds the bus idle for a guard gap before the next grant.
//
// Ports:
//   clk    system clock
//   reset  synchronous, active-high reset
//   bus    rtc_bus_scheduler_if.master (requests, strobes, starts, acks, status)
//
// Parameters:
//   REFRESH_CYCLES  cycles between periodic refresh requests (>= 2)
//   GAP_CYCLES      idle guard cycles after each transaction (0 allowed)
//   TIMEOUT_CYCLES  per-transaction watchdog limit
//
// Build option:
//   SCHED_TIMEOUT_EN  when defined, a watchdog aborts a transaction whose
//                     completion strobe never arrives and pulses timeout_err
//                     together with the normal ack. When undefined the block
//                     waits indefinitely and timeout_err is tied low.
// -----------------------------------------------------------------------------
module rtc_bus_scheduler #(
    parameter int REFRESH_CYCLES = 1000000,
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                 clk,
    input  logic                 reset,
    rtc_bus_scheduler_if.master  bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_READ  = 2'd2;
    localparam logic [1:0] S_GAP   = 2'd3;

    localparam logic [1:0] SRC_NONE    = 2'b00;
    localparam logic [1:0] SRC_WRITE   = 2'b01;
    localparam logic [1:0] SRC_READ    = 2'b10;
    localparam logic [1:0] SRC_REFRESH = 2'b11;

    localparam int RC_W  = $clog2(REFRESH_CYCLES);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [RC_W-1:0]  RC_LAST  = RC_W'(REFRESH_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

    // With a zero-length gap a finished transaction returns straight to IDLE.
    localparam logic [1:0] S_AFTER_XFER = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;

    logic [1:0]       state_q, state_d;
    logic [1:0]       src_q, src_d;
    logic [RC_W-1:0]  refresh_cnt_q, refresh_cnt_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic             refresh_pend_q, refresh_pend_d;
    logic             last_user_q, last_user_d;
    logic             escribe_q, escribe_d;
    logic             lee_q, lee_d;
    logic             wr_ack_q, wr_ack_d;
    logic             rd_ack_q, rd_ack_d;
    logic             refresh_done_q, refresh_done_d;
    logic             busy_q, busy_d;
    logic             timeout_err_d;

    logic             refresh_tick_s;
    logic             grant_refresh_s;
    logic             wd_expire_s;

    // Free-running refresh interval counter; terminal count raises a tick.
    always_comb begin
        refresh_tick_s = (refresh_cnt_q == RC_LAST);
        if (refresh_tick_s) begin
            refresh_cnt_d = {RC_W{1'b0}};
        end else begin
            refresh_cnt_d = refresh_cnt_q + {{(RC_W-1){1'b0}}, 1'b1};
        end
    end

    // Arbitration, transaction sequencing and completion pulses.
    always_comb begin
        state_d         = state_q;
        src_d           = src_q;
        last_user_d     = last_user_q;
        gap_cnt_d       = gap_cnt_q;
        wr_ack_d        = 1'b0;
        rd_ack_d        = 1'b0;
        refresh_done_d  = 1'b0;
        timeout_err_d   = 1'b0;
        grant_refresh_s = 1'b0;

        case (state_q)
            S_IDLE: begin
                // A pending refresh beats users if the previous grant went to
                // a user, so a steady user stream cannot starve refresh.
                if (refresh_pend_q && last_user_q) begin
                    state_d         = S_READ;
                    src_d           = SRC_REFRESH;
                    last_user_d     = 1'b0;
                    grant_refresh_s = 1'b1;
                end else if (bus.wr_req) begin
                    state_d     = S_WRITE;
                    src_d       = SRC_WRITE;
                    last_user_d = 1'b1;
                end else if (bus.rd_req) begin
                    state_d     = S_READ;
                    src_d       = SRC_READ;
                    last_user_d = 1'b1;
                end else if (refresh_pend_q) begin
                    state_d         = S_READ;
                    src_d           = SRC_REFRESH;
                    last_user_d     = 1'b0;
                    grant_refresh_s = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WRITE: begin
                // Only t_esc counts here; a stray t_lect is ignored.
                if (bus.t_esc) begin
                    state_d   = S_AFTER_XFER;
                    gap_cnt_d = {GAP_W{1'b0}};
                    wr_ack_d  = 1'b1;
                end else if (wd_expire_s) begin
                    state_d       = S_AFTER_XFER;
                    gap_cnt_d     = {GAP_W{1'b0}};
                    wr_ack_d      = 1'b1;
                    timeout_err_d = 1'b1;
                end else begin
                    state_d = S_WRITE;
                end
            end
            S_READ: begin
                // Only t_lect counts here; the ack follows the owner.
                if (bus.t_lect || wd_expire_s) begin
                    state_d        = S_AFTER_XFER;
                    gap_cnt_d      = {GAP_W{1'b0}};
                    rd_ack_d       = (src_q == SRC_READ);
                    refresh_done_d = (src_q == SRC_REFRESH);
                    timeout_err_d  = ~bus.t_lect;
                end else begin
                    state_d = S_READ;
                end
            end
            S_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + {{(GAP_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Refresh pending flag: a single-deep request, a tick while pending is lost.
    always_comb begin
        if (refresh_tick_s) begin
            refresh_pend_d = 1'b1;
        end else if (grant_refresh_s) begin
            refresh_pend_d = 1'b0;
        end else begin
            refresh_pend_d = refresh_pend_q;
        end
    end

    // Level outputs follow the next state so they rise on the grant edge.
    always_comb begin
        escribe_d = (state_d == S_WRITE);
        lee_d     = (state_d == S_READ);
        busy_d    = (state_d != S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            src_q          <= SRC_NONE;
            refresh_cnt_q  <= {RC_W{1'b0}};
            gap_cnt_q      <= {GAP_W{1'b0}};
            refresh_pend_q <= 1'b0;
            last_user_q    <= 1'b0;
            escribe_q      <= 1'b0;
            lee_q          <= 1'b0;
            wr_ack_q       <= 1'b0;
            rd_ack_q       <= 1'b0;
            refresh_done_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            src_q          <= src_d;
            refresh_cnt_q  <= refresh_cnt_d;
            gap_cnt_q      <= gap_cnt_d;
            refresh_pend_q <= refresh_pend_d;
            last_user_q    <= last_user_d;
            escribe_q      <= escribe_d;
            lee_q          <= lee_d;
            wr_ack_q       <= wr_ack_d;
            rd_ack_q       <= rd_ack_d;
            refresh_done_q <= refresh_done_d;
            busy_q         <= busy_d;
        end
    end

`ifdef SCHED_TIMEOUT_EN
    localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
    logic            timeout_err_q;

    // Watchdog: counts cycles spent in WRITE/READ, cleared whenever idle so
    // each grant starts from zero.
    always_comb begin
        if ((state_q == S_WRITE) || (state_q == S_READ)) begin
            wd_expire_s = (wd_cnt_q == WD_LAST);
            wd_cnt_d    = wd_cnt_q + {{(WD_W-1){1'b0}}, 1'b1};
        end else begin
            wd_expire_s = 1'b0;
            wd_cnt_d    = {WD_W{1'b0}};
        end
    end

    // Watchdog counter and timeout pulse registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wd_cnt_q      <= {WD_W{1'b0}};
            timeout_err_q <= 1'b0;
        end else begin
            wd_cnt_q      <= wd_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign bus.timeout_err = timeout_err_q;
`else
    logic unused_timeout_s;

    assign wd_expire_s      = 1'b0;
    assign unused_timeout_s = timeout_err_d | (TIMEOUT_CYCLES == 0);
    assign bus.timeout_err  = 1'b0;
`endif

    assign bus.escribe      = escribe_q;
    assign bus.lee          = lee_q;
    assign bus.wr_ack       = wr_ack_q;
    assign bus.rd_ack       = rd_ack_q;
    assign bus.refresh_done = refresh_done_q;
    assign bus.busy         = busy_q;
    assign bus.src          = src_q;

endmodule
